// File: rtl/fb_frame_if.sv
// Pixel-request and frame-buffer write bus shared by the pixel source, the
// frame controller and the frame-buffer RAM.
interface fb_frame_if #(
   parameter int unsigned ADDR_W = 19
) ();
   logic              px_valid;
   logic              px_ready;
   logic [9:0]        px_x;
   logic [9:0]        px_y;
   logic [7:0]        px_r;
   logic [7:0]        px_g;
   logic [7:0]        px_b;
   logic              px_last;
   logic              wr_en;
   logic              wr_bank;
   logic [ADDR_W-1:0] wr_addr;
   logic [23:0]       wr_data;

   modport master (
      output px_valid, px_x, px_y, px_r, px_g, px_b, px_last,
      input  px_ready, wr_en, wr_bank, wr_addr, wr_data
   );

   modport slave (
      input  px_valid, px_x, px_y, px_r, px_g, px_b, px_last,
      output px_ready, wr_en, wr_bank, wr_addr, wr_data
   );
endinterface

// File: rtl/fb_frame_ctrl.sv
// Double-buffer frame controller: clears the back bank, turns (x, y, rgb) pixel
// requests into linear RAM writes, and swaps banks on the next vblank rising edge.
module fb_frame_ctrl #(
   parameter int unsigned H_RES     = 640,
   parameter int unsigned V_RES     = 480,
   parameter int unsigned ADDR_W    = 19,
   parameter bit          CLEAR_EN  = 1'b1,
   parameter logic [23:0] CLEAR_RGB = 24'h000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vblank,
   fb_frame_if.slave   bus,
   output logic        front_sel,
   output logic        swap,
   output logic        busy,
   output logic [15:0] frame_cnt
);

   localparam int unsigned NPix = H_RES * V_RES;
   localparam int unsigned CntW = ADDR_W + 1;

   typedef enum logic [1:0] {StClear, StDraw, StWaitVb, StSwap} state_e;

   localparam state_e StReset = CLEAR_EN ? StClear : StDraw;

   state_e            state_q, state_d;
   logic [CntW-1:0]   clr_cnt_q, clr_cnt_d;
   logic              vb_q;
   logic              ready_q, ready_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [23:0]       wr_data_q, wr_data_d;
   logic              front_q, front_d;
   logic              swap_q, swap_d;
   logic [15:0]       frame_q, frame_d;
   logic              accept;
   logic              in_range;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      front_d   = front_q;
      swap_d    = 1'b0;
      frame_d   = frame_q;
      accept    = bus.px_valid & ready_q;
      in_range  = (32'(bus.px_x) < H_RES) && (32'(bus.px_y) < V_RES);

      unique case (state_q)
         StClear: begin
            // Counter reaching NPix means the last clear write is already on the bus.
            if (clr_cnt_q == CntW'(NPix)) begin
               state_d = StDraw;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = clr_cnt_q[ADDR_W-1:0];
               wr_data_d = CLEAR_RGB;
               clr_cnt_d = clr_cnt_q + CntW'(1);
            end
         end
         StDraw: begin
            if (accept) begin
               if (in_range) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = ADDR_W'(32'(bus.px_y) * H_RES + 32'(bus.px_x));
                  wr_data_d = {bus.px_r, bus.px_g, bus.px_b};
               end
               if (bus.px_last) begin
                  state_d = StWaitVb;
               end
            end
         end
         StWaitVb: begin
            if (vblank && !vb_q) begin
               state_d = StSwap;
               front_d = ~front_q;
               swap_d  = 1'b1;
               frame_d = frame_q + 16'd1;
            end
         end
         StSwap: begin
            state_d   = CLEAR_EN ? StClear : StDraw;
            clr_cnt_d = '0;
         end
         default: state_d = StReset;
      endcase

      ready_d = (state_d == StDraw);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StReset;
         clr_cnt_q <= '0;
         vb_q      <= 1'b0;
         ready_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         front_q   <= 1'b0;
         swap_q    <= 1'b0;
         frame_q   <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         vb_q      <= vblank;
         ready_q   <= ready_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         front_q   <= front_d;
         swap_q    <= swap_d;
         frame_q   <= frame_d;
      end
   end

   assign bus.px_ready = ready_q;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_bank  = ~front_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign front_sel    = front_q;
   assign swap         = swap_q;
   assign busy         = (state_q != StDraw);
   assign frame_cnt    = frame_q;

endmodule

// File: tb/tb_fb_frame_ctrl.sv
// Scoreboard bench for fb_frame_ctrl on an 8x4 frame: expected RAM writes are queued
// by the stimulus side and consumed by a negedge monitor.
module tb_fb_frame_ctrl;

   localparam int unsigned H  = 8;
   localparam int unsigned V  = 4;
   localparam int unsigned AW = 5;
   localparam logic [23:0] CLR = 24'h000000;

   typedef struct {
      logic          bank;
      logic [AW-1:0] addr;
      logic [23:0]   data;
   } wr_t;

   logic        clk;
   logic        rst_n;
   logic        vblank;
   logic        front_sel;
   logic        swap;
   logic        busy;
   logic [15:0] frame_cnt;

   fb_frame_if #(.ADDR_W(AW)) bus ();

   fb_frame_ctrl #(
      .H_RES    (H),
      .V_RES    (V),
      .ADDR_W   (AW),
      .CLEAR_EN (1'b1),
      .CLEAR_RGB(CLR)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .vblank   (vblank),
      .bus      (bus),
      .front_sel(front_sel),
      .swap     (swap),
      .busy     (busy),
      .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_wr_cyc = 0;
   int   swap_cnt = 0;
   bit   mon_en = 0;
   bit   m_front = 0;
   wr_t  exp_q[$];
   int   wr_cyc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("wr_bank_not_front", 32'(bus.wr_bank), 32'(!front_sel));
         if (swap) swap_cnt++;
         if (bus.wr_en) begin
            wr_cyc_q.push_back(cyc);
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr %0d data %0h with nothing expected",
                        bus.wr_addr, bus.wr_data);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
               chk("wr_data", 32'(bus.wr_data), 32'(e.data));
               chk("wr_bank", 32'(bus.wr_bank), 32'(e.bank));
            end
         end
      end
   end

   task automatic push_clear();
      for (int i = 0; i < int'(H * V); i++) begin
         wr_t e;
         e.bank = !m_front;
         e.addr = AW'(i);
         e.data = CLR;
         exp_q.push_back(e);
      end
   endtask

   // Reference rule: in-range pixels land at y*H+x of the back bank, others vanish.
   task automatic push_pixel(input int x, input int y, input logic [7:0] r,
                             input logic [7:0] g, input logic [7:0] b);
      if (x < int'(H) && y < int'(V)) begin
         wr_t e;
         e.bank = !m_front;
         e.addr = AW'(y * int'(H) + x);
         e.data = {r, g, b};
         exp_q.push_back(e);
      end
   endtask

   task automatic drive_px(input int x, input int y, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b, input bit last);
      bus.px_valid = 1'b1;
      bus.px_x     = 10'(x);
      bus.px_y     = 10'(y);
      bus.px_r     = r;
      bus.px_g     = g;
      bus.px_b     = b;
      bus.px_last  = last;
   endtask

   task automatic send(input int x, input int y, input logic [7:0] r,
                       input logic [7:0] g, input logic [7:0] b, input bit last);
      bit acc;
      int n;
      @(posedge clk); #1;
      drive_px(x, y, r, g, b, last);
      acc = 0;
      n   = 0;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = bus.px_ready;
         n++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: pixel (%0d,%0d) never accepted", x, y);
      end else begin
         push_pixel(x, y, r, g, b);
      end
      @(posedge clk); #1;
      bus.px_valid = 1'b0;
      bus.px_last  = 1'b0;
   endtask

   task automatic burst(input int n, input bit last_on_end);
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         int x, y;
         logic [7:0] r, g, b;
         x = $urandom_range(0, H - 1);
         y = $urandom_range(0, V - 1);
         r = 8'($urandom);
         g = 8'($urandom);
         b = 8'($urandom);
         drive_px(x, y, r, g, b, last_on_end && (i == n - 1));
         @(negedge clk);
         chk("burst_ready", 32'(bus.px_ready), 32'd1);
         if (bus.px_ready) push_pixel(x, y, r, g, b);
         @(posedge clk); #1;
      end
      bus.px_valid = 1'b0;
      bus.px_last  = 1'b0;
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!bus.px_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.px_ready) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: px_ready never rose", name);
      end else begin
         chk({name, "_ready_after_last"}, 32'(cyc - last_wr_cyc), 32'd1);
         chk({name, "_all_cleared"}, 32'(exp_q.size()), 32'd0);
      end
   endtask

   task automatic wait_swap(input int rise_cyc);
      int n;
      n = 0;
      @(negedge clk);
      while (!swap && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!swap) begin
         checks++;
         errors++;
         $display("FAIL swap_timeout: no swap pulse");
      end else begin
         chk("swap_latency", 32'(cyc - rise_cyc), 32'd1);
         m_front = !m_front;
         chk("front_after_swap", 32'(front_sel), 32'(m_front));
         chk("wr_bank_after_swap", 32'(bus.wr_bank), 32'(!m_front));
         push_clear();
      end
   endtask

   task automatic vblank_rise();
      int rc;
      @(posedge clk); #1;
      vblank = 1'b1;
      rc = cyc;
      wait_swap(rc);
   endtask

   initial begin
      rst_n        = 1'b0;
      vblank       = 1'b0;
      bus.px_valid = 1'b0;
      bus.px_x     = '0;
      bus.px_y     = '0;
      bus.px_r     = '0;
      bus.px_g     = '0;
      bus.px_b     = '0;
      bus.px_last  = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_front_sel", 32'(front_sel), 32'd0);
      chk("rst_wr_bank", 32'(bus.wr_bank), 32'd1);
      chk("rst_swap", 32'(swap), 32'd0);
      chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
      chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
      chk("rst_px_ready", 32'(bus.px_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      push_clear();
      mon_en = 1;
      rst_n  = 1'b1;
      wait_ready("clear0");
      chk("draw_busy", 32'(busy), 32'd0);

      send(3, 2, 8'd66, 8'd233, 8'd245, 1'b0);
      send(8, 0, 8'd1, 8'd2, 8'd3, 1'b0);
      send(0, 4, 8'd4, 8'd5, 8'd6, 1'b0);
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         send($urandom_range(0, H + 2), $urandom_range(0, V + 1),
              8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      end

      // vblank already high when the frame ends must not trigger a swap.
      vblank = 1'b1;
      send(7, 3, 8'hAA, 8'h55, 8'h0F, 1'b1);
      @(negedge clk);
      chk("ready_after_last", 32'(bus.px_ready), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("no_swap_on_high_vblank", 32'(swap_cnt), 32'd0);
      vblank = 1'b0;
      repeat (3) @(posedge clk);
      vblank_rise();
      chk("frame_cnt_1", 32'(frame_cnt), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("single_swap_pulse", 32'(swap_cnt), 32'd1);

      // Reset partway through the clear of bank 0.
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      m_front = 0;
      chk("midrst_wr_en", 32'(bus.wr_en), 32'd0);
      chk("midrst_front_sel", 32'(front_sel), 32'd0);
      chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("midrst_px_ready", 32'(bus.px_ready), 32'd0);
      push_clear();
      wait_ready("clear_restart");

      wr_cyc_q.delete();
      burst(10, 1'b1);
      @(negedge clk);
      chk("ready_after_burst_last", 32'(bus.px_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("burst_write_count", 32'(wr_cyc_q.size()), 32'd10);
      if (wr_cyc_q.size() == 10) begin
         chk("burst_no_bubbles", 32'(wr_cyc_q[9] - wr_cyc_q[0]), 32'd9);
      end
      vblank = 1'b0;
      repeat (2) @(posedge clk);
      vblank_rise();
      chk("frame_cnt_after_rst", 32'(frame_cnt), 32'd1);
      wait_ready("clear2");
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fb_frame_ctrl.md
# fb_frame_ctrl

Double-buffer frame controller between the pixel-generating logic and the frame-buffer RAM. It clears the back buffer and accepts (x, y, RGB) pixel writes over a valid/ready handshake. It converts each pixel write into a linear RAM write on the back bank. At the end of a frame it waits for the next vertical-blank rising edge, swaps front and back banks, and emits a one-cycle `swap` pulse.

## Interface
- `H_RES`, 640, active pixels per line.
- `V_RES`, 480, active lines per frame.
- `ADDR_W`, 19, per-bank address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- `CLEAR_EN`, 1, clear the back bank before accepting pixels.
- `CLEAR_RGB`, 24'h000000, fill colour used by the clear pass.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset; synchronous, active-low.
- `vblank`  in  1  level from the video timing block; high during vertical blank.
- `px_valid`  in  1  pixel request.
- `px_ready`  out  1  pixel accepted this cycle when `px_valid` is also high.
- `px_x`  in  10  pixel column.
- `px_y`  in  10  pixel row.
- `px_r`, `px_g`, `px_b`  in  8 each  pixel colour.
- `px_last`  in  1  qualifies the final pixel of a frame; sampled on accept.
- `wr_en`  out  1  RAM write strobe.
- `wr_bank`  out  1  bank being written; always equals ~`front_sel`.
- `wr_addr`  out  ADDR_W  linear address within the bank.
- `wr_data`  out  24  {r, g, b}.
- `front_sel`  out  1  bank currently scanned out by the display.
- `swap`  out  1  one-cycle pulse, coincident with the `front_sel` toggle.
- `busy`  out  1  high in every state except DRAW.
- `frame_cnt`  out  16  completed swaps; wraps from 16'hFFFF to 0.

## Operation
- States: CLEAR, DRAW, WAIT_VB, SWAP.
- After reset: CLEAR if `CLEAR_EN`=1, else DRAW.
- CLEAR
  - Internal counter walks 0 .. H_RES*V_RES-1.
  - One write per cycle: `wr_addr`=counter, `wr_data`=CLEAR_RGB.
  - `px_ready`=0.
  - After the last address, go to DRAW.
- DRAW
  - `px_ready`=1.
  - On accept with `px_x`<H_RES and `px_y`<V_RES: write `wr_addr` = `px_y`*H_RES + `px_x`, `wr_data` = {`px_r`,`px_g`,`px_b`}.
  - Out-of-range pixels are accepted and dropped; no write is issued.
  - Accept with `px_last`=1 goes to WAIT_VB. The last pixel is still written if in range.
- WAIT_VB
  - `px_ready`=0, no writes.
  - Rising edge of `vblank` (registered previous sample 0, current 1) goes to SWAP.
  - A `vblank` already high on entry does not count; the controller waits for the next edge.
- SWAP (one cycle)
  - `front_sel` toggles, `swap`=1, `frame_cnt` increments.
  - Next state is CLEAR if `CLEAR_EN`, else DRAW.
- Address arithmetic uses a constant multiply by H_RES, computed at full width, then truncated to ADDR_W. In-range inputs never overflow.
- The internal `vblank` edge register is also cleared by reset.

## Timing
- Reset values: `front_sel`=0, `wr_bank`=1, `swap`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `px_ready`=0, `busy`=1, `frame_cnt`=0. State is CLEAR (or DRAW if `CLEAR_EN`=0).
- Write outputs are registered: an accept in cycle N produces `wr_en`/`wr_addr`/`wr_data` in cycle N+1.
- `px_ready` is a registered function of state. It is 1 in the first DRAW cycle and 0 in the cycle after the `px_last` accept.
- Back-to-back accepts sustain one write per cycle.
- Clear pass takes exactly H_RES*V_RES cycles. The first DRAW cycle follows the cycle of the last clear write.
- `swap` and `front_sel` change in the cycle after the `vblank` edge is detected.
- `wr_bank` never equals `front_sel`, including the cycle of a swap. No write is pending during SWAP.
- `rst_n` low mid-clear or mid-frame:
  - abandons the operation at the next edge;
  - drops the pending write (`wr_en`=0 that cycle);
  - restores `front_sel`=0.

## Test plan
- Reset, H_RES=8, V_RES=4, CLEAR_EN=1 -> exactly 32 writes, addresses 0..31, data 0, `wr_bank`=1. `px_ready` rises in the cycle after address 31.
- DRAW, pixel (3,2) rgb (66,233,245) -> next cycle `wr_en`=1, `wr_addr`=19, `wr_data`=24'h42E9F5.
- Pixels (8,0) and (0,4) valid -> both accepted with `px_ready`=1, no `wr_en`.
- Accept `px_last`, `vblank` already high, then low, then high -> exactly one `swap` pulse, one cycle after the second rise. `front_sel` goes 0->1, `frame_cnt`=1, `wr_bank`=0.
- Continuous `px_valid` for 10 cycles -> 10 consecutive writes with no bubbles. `px_last` on the 10th accept -> `px_ready`=0 the next cycle.
- `rst_n` low for one cycle midway through a clear -> `wr_en`=0, `front_sel`=0, and the clear restarts at address 0.
